// File: rtl/mult_pkg.sv
// Shared definitions for the multi-cycle multiplier: op encodings, FSM states
// and the default operand width.
package mult_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // Op is a raw 2-bit field; 2'b11 is legal and behaves as MULTU.
   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_MULTU = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

   function automatic logic is_signed_op(input logic [1:0] op);
      return (op == OP_MUL) || (op == OP_MULT);
   endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/response bundle between EX control and the multiply sequencer.
interface mult_sequencer_if import mult_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Flush;
   logic             Busy;
   logic             Stall;
   logic             Done;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] Hi;

   modport master (
      output Start, Op, A, B, Flush,
      input  Busy, Stall, Done, Result, Hi
   );

   modport slave (
      input  Start, Op, A, B, Flush,
      output Busy, Stall, Done, Result, Hi
   );
endinterface

// File: rtl/mult_datapath.sv
// Radix-2 shift-add datapath on operand magnitudes; sign is reapplied to the
// full product in the FIX step.
module mult_datapath import mult_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             fix_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] hi_o
);

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               wr_hi_q, wr_hi_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   hi_q, hi_d;

   logic               signed_op;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_fixed;

   always_comb begin
      signed_op = is_signed_op(op_i);
      // Carry out of the upper-half add becomes the new MSB after the shift.
      sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      acc_fixed = neg_q ? -acc_q : acc_q;

      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      wr_hi_d  = wr_hi_q;
      result_d = result_q;
      hi_d     = hi_q;

      if (load_i) begin
         mcand_d  = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
         mplier_d = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;
         neg_d    = signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
         wr_hi_d  = (op_i != OP_MUL);
         acc_d    = '0;
      end else if (step_i) begin
         acc_d    = {sum, acc_q[WIDTH-1:1]};
         mplier_d = mplier_q >> 1;
      end else if (fix_i) begin
         result_d = acc_fixed[WIDTH-1:0];
         if (wr_hi_q) begin
            hi_d = acc_fixed[2*WIDTH-1:WIDTH];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         wr_hi_q  <= 1'b0;
         result_q <= '0;
         hi_q     <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         wr_hi_q  <= wr_hi_d;
         result_q <= result_d;
         hi_q     <= hi_d;
      end
   end

   assign result_o = result_q;
   assign hi_o     = hi_q;

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle multiply controller: FSM, iteration counter, stall/done and
// flush handling around mult_datapath.
module mult_sequencer import mult_pkg::*; #(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic            Clk,
   input  logic            Rst,
   mult_sequencer_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            load, step, fix;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Start && !bus.Flush) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.Flush) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = FIX;
               end
            end
         end
         FIX: begin
            if (bus.Flush) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               fix     = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.Busy  = (state_q == RUN) || (state_q == FIX);
   assign bus.Done  = (state_q == DONE);
   assign bus.Stall = bus.Busy || (bus.Start && (state_q == IDLE));

   mult_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .Clk      (Clk),
      .Rst      (Rst),
      .load_i   (load),
      .step_i   (step),
      .fix_i    (fix),
      .op_i     (bus.Op),
      .a_i      (bus.A),
      .b_i      (bus.B),
      .result_o (bus.Result),
      .hi_o     (bus.Hi)
   );

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus pushes expected products,
// a negedge monitor pops and compares on every Done pulse.
module tb_mult_sequencer;
   import mult_pkg::*;

   localparam int unsigned LAT = 34;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      int unsigned cyc;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   int unsigned cyc = 0;
   int unsigned errors = 0;
   int unsigned checks = 0;
   exp_t        q[$];
   logic [31:0] mdl_res = '0;
   logic [31:0] mdl_hi  = '0;

   mult_sequencer_if #(.WIDTH(32)) bus ();

   mult_sequencer #(.WIDTH(32)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (op == OP_MUL || op == OP_MULT) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Record an accepted request in the model and queue its expected response.
   task automatic expect_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int unsigned start_cyc);
      logic [63:0] p;
      p = ref_prod(op, a, b);
      mdl_res = p[31:0];
      if (op != OP_MUL) mdl_hi = p[63:32];
      q.push_back('{res: mdl_res, hi: mdl_hi, cyc: start_cyc});
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit will_finish);
      bus.Op = op; bus.A = a; bus.B = b; bus.Start = 1'b1;
      #1 check("stall_on_start", 64'(bus.Stall), 64'd1);
      if (will_finish) expect_op(op, a, b, cyc);
      tick();
      bus.Start = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned budget = 80;
      while (q.size() != 0 && budget != 0) begin
         tick();
         budget--;
      end
      if (q.size() != 0) begin
         check("done_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge Clk) begin
      if (bus.Done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 64'(bus.Done), 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", 64'(bus.Result), 64'(e.res));
            check("hi", 64'(bus.Hi), 64'(e.hi));
            check("latency", 64'(cyc - e.cyc), 64'(LAT));
            check("busy_in_done", 64'(bus.Busy), 64'd0);
            check("stall_in_done", 64'(bus.Stall), 64'(0));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0; bus.Flush = 1'b0;
      repeat (3) tick();
      check("rst_busy", 64'(bus.Busy), 64'd0);
      check("rst_done", 64'(bus.Done), 64'd0);
      check("rst_stall", 64'(bus.Stall), 64'd0);
      check("rst_result", 64'(bus.Result), 64'd0);
      check("rst_hi", 64'(bus.Hi), 64'd0);
      Rst = 1'b1;
      tick();

      // Directed operand patterns, including the signed corner cases.
      issue(OP_MUL, 32'd7, 32'd6, 1'b1);                       wait_idle();
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);              wait_idle();
      issue(OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);      wait_idle();
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);     wait_idle();
      issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);        wait_idle();
      issue(OP_MUL, 32'h0, 32'hFFFF_FFFF, 1'b1);               wait_idle();

      // Starts during RUN and during DONE are ignored; held into IDLE it is taken.
      n = cyc;
      issue(OP_MUL, 32'd11, 32'd13, 1'b1);
      repeat (5) tick();
      bus.Op = OP_MULTU; bus.A = 32'd100; bus.B = 32'd200; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      while (cyc < n + LAT) tick();
      bus.Op = OP_MULT; bus.A = 32'hFFFF_FFF7; bus.B = 32'd1000; bus.Start = 1'b1;
      #1 check("stall_start_in_done", 64'(bus.Stall), 64'd0);
      tick();
      expect_op(OP_MULT, 32'hFFFF_FFF7, 32'd1000, cyc);
      tick();
      bus.Start = 1'b0;
      wait_idle();

      // Flush mid-RUN after a known result of 42.
      issue(OP_MUL, 32'd7, 32'd6, 1'b1);                       wait_idle();
      issue(OP_MUL, 32'd9, 32'd9, 1'b0);
      repeat (10) tick();
      bus.Flush = 1'b1;
      tick();
      bus.Flush = 1'b0;
      #1;
      check("flush_busy", 64'(bus.Busy), 64'd0);
      check("flush_stall", 64'(bus.Stall), 64'd0);
      check("flush_result", 64'(bus.Result), 64'(mdl_res));
      check("flush_hi", 64'(bus.Hi), 64'(mdl_hi));
      repeat (40) tick();
      issue(OP_MUL, 32'd9, 32'd9, 1'b1);                       wait_idle();

      // Flush beats Start in IDLE.
      bus.Op = OP_MULTU; bus.A = 32'd3; bus.B = 32'd3; bus.Start = 1'b1; bus.Flush = 1'b1;
      tick();
      bus.Start = 1'b0; bus.Flush = 1'b0;
      #1 check("flush_idle_busy", 64'(bus.Busy), 64'd0);
      repeat (40) tick();

      // Random traffic against the arithmetic model.
      for (int i = 0; i < 20; i++) begin
         issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1);
         wait_idle();
      end

      // Reset mid-RUN with a simultaneous Start discards everything.
      issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      repeat (5) tick();
      Rst = 1'b0;
      bus.Op = OP_MULT; bus.A = 32'd5; bus.B = 32'd5; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      #1;
      check("midrst_busy", 64'(bus.Busy), 64'd0);
      check("midrst_done", 64'(bus.Done), 64'd0);
      check("midrst_stall", 64'(bus.Stall), 64'd0);
      check("midrst_result", 64'(bus.Result), 64'd0);
      check("midrst_hi", 64'(bus.Hi), 64'd0);
      Rst = 1'b1;
      mdl_res = '0;
      mdl_hi  = '0;
      repeat (40) tick();
      check("midrst_idle_busy", 64'(bus.Busy), 64'd0);

      issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);       wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Multi-cycle multiply controller and datapath. Replaces the single-cycle A*B path so MUL no longer sets the EX-stage critical path.
- Sits beside the ALU in EX. Accepts a multiply request from the decode/EX control, stalls the pipeline while a radix-2 shift-add sequence runs, and returns the low word, or the HI/LO pair, with a one-cycle Done pulse.
- Supports MUL (signed, low 32 bits), MULT (signed 64) and MULTU (unsigned 64).

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH. The iteration count equals WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  00 MUL, 01 MULT, 10 MULTU, 11 treated as MULTU.
- A  input  WIDTH  multiplicand, captured on acceptance.
- B  input  WIDTH  multiplier, captured on acceptance.
- Flush  input  1  abort the in-flight operation (branch/exception squash).
- Busy  output  1  high in RUN and FIX.
- Stall  output  1  combinational: Busy | (Start & state==IDLE).
- Done  output  1  one-cycle pulse when the result is valid.
- Result  output  WIDTH  low product word; MUL destination.
- Hi  output  WIDTH  upper product word; written for MULT/MULTU only.

Behaviour:
- Reset (Rst==0 at a rising edge):
  - state=IDLE; counter=0.
  - Busy=0, Done=0, Result=0, Hi=0; internal accumulator cleared.
  - Reset overrides Start and Flush.
  - Reset mid-operation discards all work; no Done is produced.
- IDLE:
  - Start=1 -> capture Op and A, B.
  - Signed ops: store |A| and |B|; record neg = A[msb]^B[msb]. Unsigned: store raw, neg=0.
  - Clear the 2*WIDTH accumulator; counter=0; next state RUN.
- RUN, one iteration per cycle:
  - If multiplier LSB=1, add the multiplicand to the upper half of the accumulator (WIDTH+1-bit add, carry kept).
  - Shift the accumulator and carry right by 1; shift the multiplier right by 1; counter++.
  - When counter==WIDTH-1 in this cycle -> FIX.
- FIX, one cycle:
  - If neg, two's-complement negate the full 2*WIDTH accumulator.
  - Load Result=acc[WIDTH-1:0].
  - Load Hi=acc[2*WIDTH-1:WIDTH] if Op!=MUL; otherwise Hi holds its previous value.
  - Next state DONE.
- DONE, one cycle: Done=1, Busy=0; next state IDLE.
- Latency:
  - Start accepted at edge k -> RUN at edges k+1..k+WIDTH -> FIX -> Done=1 in the cycle after edge k+WIDTH+1, i.e. 34 cycles for WIDTH=32.
  - Stall is high from the Start cycle through the FIX cycle and low in the DONE cycle.
- Result and Hi hold their values until the next FIX. They are unaffected by Flush and by ignored Starts.
- Start while Busy or in DONE: ignored, not queued.
  - A new Start in the DONE cycle is not accepted; it is accepted the following cycle in IDLE.
- Flush:
  - In RUN or FIX -> next state IDLE; counter cleared; no Done; Result/Hi are not updated.
  - In DONE: Done still pulses; writeback suppression is the pipeline's responsibility.
  - In IDLE with Start=1: Flush wins and the request is not accepted.
- Signed edge cases:
  - A=0x80000000: its magnitude 0x80000000 is held correctly in WIDTH unsigned bits.
  - Zero operands yield 0, with neg allowed since negating 0 gives 0.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package mult_pkg holds:
  - the Op encodings (OP_MUL, OP_MULT, OP_MULTU);
  - the state typedef (IDLE, RUN, FIX, DONE);
  - the WIDTH default constant.
- One sub-module is natural: mult_datapath, holding the operand/accumulator registers, the WIDTH+1 adder, the shifter and the negator, driven by load/step/fix strobes.
- mult_sequencer keeps the FSM, the counter, Stall/Busy/Done and the Flush handling.

Test Plan:
- Reset, then MUL A=7, B=6 -> Stall high in the Start cycle; Done exactly 34 cycles later; Result=0x0000002A; Hi unchanged (0).
- MULT A=-3 (0xFFFFFFFD), B=5 -> Hi=0xFFFFFFFF, Result=0xFFFFFFF1. Then MULT A=0x80000000, B=0xFFFFFFFF -> Hi=0x00000000, Result=0x80000000.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Result=0x00000001. Op=11 with the same operands gives an identical result.
- Start re-asserted with different operands during RUN and in the DONE cycle -> ignored; the original result is delivered. The second request is accepted only once Start is held into IDLE.
- Flush at RUN iteration 10 of MUL 9*9 after a prior result of 42 -> IDLE next cycle, no Done, Result stays 0x2A, Stall drops. A following MUL 9*9 returns 0x51.
- Rst=0 asserted mid-RUN -> next edge: all outputs 0, IDLE, no Done pulse. Start during the same cycle as Rst=0 is not accepted.
